mcdf_formatter: RTL and testbench

- Downstream stage of the channel arbiter.
- Asks the arbiter for a channel ID, then drains one packet of words from the granted slave into an internal packet buffer.
- Requests the output bus, then streams the buffered packet to the receiver back-to-back, with start/end framing.
- Buffering the whole packet first means a stall in a slave FIFO can never stall the output burst.

---
 rtl/mcdf_fmt_pkg.sv | 12 +
 rtl/fmt_pkt_buf.sv | 38 +++
 rtl/mcdf_formatter.sv | 137 +++++++++++++
 tb/tb_mcdf_formatter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mcdf_fmt_pkg.sv
// mcdf_fmt_pkg: shared state encoding, ID sentinel and length decode for the formatter
package mcdf_fmt_pkg;

   typedef enum logic [2:0] {IDLE, IDREQ, IDWAIT, COLLECT, REQ, SEND} fmt_state_e;

   localparam logic [1:0] ID_NONE = 2'd3;

   function automatic logic [5:0] decode_len(input logic [2:0] sel);
      return sel == 3'd0 ? 6'd4 : sel == 3'd1 ? 6'd8 : sel == 3'd2 ? 6'd16 : 6'd32;
   endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// fmt_pkt_buf: single-packet word buffer with write/read pointers and combinational read
module fmt_pkt_buf #(
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          clr_i,
   input  logic          wr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          rd_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;

   // pointers restart at every new packet; clear wins over any access
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q <= rd_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
      end

   // storage needs no reset: a word is only read after it was written this packet
   always_ff @(posedge clk_i)
      if (wr_i) mem_q[wr_ptr_q] <= wdata_i;

   assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/mcdf_formatter.sv
// mcdf_formatter: fetches a channel ID, buffers one packet, then bursts it out framed
// Optional packet parity output enabled by defining MCDF_FMT_PARITY_EN.
module mcdf_formatter
   import mcdf_fmt_pkg::*;
#(
   parameter int DW      = 32,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   output logic             f2a_id_req_o,
   output logic             f2a_ack_o,
   input  logic             a2f_val_i,
   input  logic [1:0]       a2f_id_i,
   input  logic [DW-1:0]    a2f_data_i,
   input  logic [2:0]       a2f_pkglen_sel_i,
   output logic             fmt_req_o,
   input  logic             fmt_grant_i,
   output logic [1:0]       fmt_chid_o,
   output logic [LEN_W-1:0] fmt_length_o,
   output logic [DW-1:0]    fmt_data_o,
   output logic             fmt_start_o,
   output logic             fmt_end_o
`ifdef MCDF_FMT_PARITY_EN
   ,
   output logic             fmt_parity_o
`endif
);

   fmt_state_e       state_q, state_d;
   logic [1:0]       chid_q, chid_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             buf_clr, buf_wr, buf_rd;
   logic [DW-1:0]    buf_rdata;

   fmt_pkt_buf #(.DW(DW), .DEPTH(MAX_LEN)) u_buf (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clr_i   (buf_clr),
      .wr_i    (buf_wr),
      .wdata_i (a2f_data_i),
      .rd_i    (buf_rd),
      .rdata_o (buf_rdata)
   );

   // state, latched packet header and the shared collect/send word counter
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         state_q <= IDLE;
         chid_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         chid_q  <= chid_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end

   // next state and Moore/Mealy outputs; every output defaults to 0
   always_comb begin
      state_d      = state_q;
      chid_d       = chid_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      buf_clr      = 1'b0;
      buf_wr       = 1'b0;
      buf_rd       = 1'b0;
      f2a_id_req_o = 1'b0;
      f2a_ack_o    = 1'b0;
      fmt_req_o    = 1'b0;
      fmt_chid_o   = '0;
      fmt_length_o = '0;
      fmt_data_o   = '0;
      fmt_start_o  = 1'b0;
      fmt_end_o    = 1'b0;
      unique case (state_q)
         IDLE: state_d = IDREQ;
         IDREQ: begin
            f2a_id_req_o = 1'b1;
            state_d      = IDWAIT;
         end
         IDWAIT:
            if (a2f_id_i == ID_NONE) state_d = IDLE;
            else begin
               chid_d  = a2f_id_i;
               len_d   = LEN_W'(decode_len(a2f_pkglen_sel_i));
               cnt_d   = '0;
               buf_clr = 1'b1;
               state_d = COLLECT;
            end
         COLLECT: begin
            f2a_ack_o = a2f_val_i && (cnt_q < len_q);
            buf_wr    = f2a_ack_o;
            if (buf_wr) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) begin
                  cnt_d   = '0;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            fmt_req_o    = 1'b1;
            fmt_chid_o   = chid_q;
            fmt_length_o = len_q;
            if (fmt_grant_i) state_d = SEND;
         end
         SEND: begin
            fmt_chid_o   = chid_q;
            fmt_length_o = len_q;
            fmt_data_o   = buf_rdata;
            fmt_start_o  = cnt_q == '0;
            fmt_end_o    = cnt_q == len_q - LEN_W'(1);
            buf_rd       = 1'b1;
            cnt_d        = fmt_end_o ? '0 : cnt_q + LEN_W'(1);
            state_d      = fmt_end_o ? IDLE : SEND;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MCDF_FMT_PARITY_EN
   logic par_q;

   // running XOR of every collected bit, restarted when a new packet is accepted
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) par_q <= 1'b0;
      else if (buf_clr) par_q <= 1'b0;
      else if (buf_wr) par_q <= par_q ^ (^a2f_data_i);

   assign fmt_parity_o = fmt_end_o & par_q;
`endif

endmodule

// File: tb/tb_mcdf_formatter.sv
// tb_mcdf_formatter: randomized self-checking bench with a packet-level reference model
module tb_mcdf_formatter;

   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          f2a_id_req_o, f2a_ack_o;
   logic          a2f_val_i = 1'b0;
   logic [1:0]    a2f_id_i = 2'd3;
   logic [DW-1:0] a2f_data_i = '0;
   logic [2:0]    a2f_pkglen_sel_i = '0;
   logic          fmt_req_o;
   logic          fmt_grant_i = 1'b0;
   logic [1:0]    fmt_chid_o;
   logic [5:0]    fmt_length_o;
   logic [DW-1:0] fmt_data_o;
   logic          fmt_start_o, fmt_end_o;
`ifdef MCDF_FMT_PARITY_EN
   logic          fmt_parity_o;
`endif

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] fixed_q[$];

   always #5 clk_i = ~clk_i;

   mcdf_formatter dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .f2a_id_req_o     (f2a_id_req_o),
      .f2a_ack_o        (f2a_ack_o),
      .a2f_val_i        (a2f_val_i),
      .a2f_id_i         (a2f_id_i),
      .a2f_data_i       (a2f_data_i),
      .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
      .fmt_req_o        (fmt_req_o),
      .fmt_grant_i      (fmt_grant_i),
      .fmt_chid_o       (fmt_chid_o),
      .fmt_length_o     (fmt_length_o),
      .fmt_data_o       (fmt_data_o),
      .fmt_start_o      (fmt_start_o),
      .fmt_end_o        (fmt_end_o)
`ifdef MCDF_FMT_PARITY_EN
      ,
      .fmt_parity_o     (fmt_parity_o)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int ref_len(input int sel);
      case (sel)
         0: return 4;
         1: return 8;
         2: return 16;
         default: return 32;
      endcase
   endfunction

   function automatic logic [63:0] all_outs();
      return {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o};
   endfunction

   // val_mode: 0 continuous, 1 every other cycle, 2 random
   task automatic run_packet(input int id, input int sel, input int val_mode, input int gdly,
                             input bit glitch, input int rst_at);
      int            len;
      logic [DW-1:0] words[$];
      logic          par;
      int            idx, acks, bad, cyc, last;
      bit            seen;
      len = ref_len(sel);
      par = 1'b0;
      idx = 0; acks = 0; bad = 0; cyc = 0; last = 0; seen = 0;
      for (int k = 0; k < len; k++) words.push_back(fixed_q.size() == len ? fixed_q[k] : DW'($urandom));
      fixed_q.delete();
      foreach (words[k]) par ^= ^words[k];
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         seen = f2a_id_req_o;
      end
      check("id_req_seen", 64'(seen), 64'd1);
      if (!seen) return;
      a2f_id_i = 2'(id);
      a2f_pkglen_sel_i = 3'(sel);
      while (!fmt_req_o && cyc < 400) begin
         tick();
         cyc++;
         if (!fmt_req_o) begin
            a2f_val_i = val_mode == 0 ? 1'b1 : val_mode == 1 ? (cyc % 2 == 1) : ($urandom_range(0, 2) != 0);
            a2f_data_i = idx < len ? words[idx] : DW'($urandom);
            if (glitch) fmt_grant_i = 1'($urandom_range(0, 1));
            #1;
            if (f2a_ack_o && !a2f_val_i) bad++;
            if (f2a_ack_o) begin
               acks++;
               idx++;
               last = cyc;
            end
         end
      end
      a2f_val_i = 1'b0;
      fmt_grant_i = 1'b0;
      a2f_id_i = 2'd3;
      check("req_seen", 64'(fmt_req_o), 64'd1);
      check("ack_count", 64'(acks), 64'(len));
      check("ack_without_val", 64'(bad), 64'd0);
      if (!fmt_req_o) return;
      check("req_latency", 64'(cyc - last), 64'd1);
      repeat (gdly) tick();
      check("req_hold", {fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o},
            {1'b1, 1'b0, 1'b0, 2'(id), 6'(len)});
      fmt_grant_i = 1'b1;
      tick();
      fmt_grant_i = 1'b0;
      for (int i = 0; i < len; i++) begin
         check("frame", {fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o},
               {1'b0, (i == 0), (i == len - 1), 2'(id), 6'(len)});
         check("data", 64'(fmt_data_o), 64'(words[i]));
`ifdef MCDF_FMT_PARITY_EN
         check("parity", 64'(fmt_parity_o), 64'((i == len - 1) ? par : 1'b0));
`endif
         if (i == rst_at) begin
            rstn_i = 1'b0;
            #1;
            check("reset_mid_send", all_outs(), 64'd0);
            @(negedge clk_i);
            @(negedge clk_i);
            rstn_i = 1'b1;
            return;
         end
         tick();
      end
      check("idle_after_send", all_outs(), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, prev, badgap, acks, reqs;
      pulses = 0; prev = -1; badgap = 0; acks = 0; reqs = 0;
      a2f_val_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      for (int c = 0; c < 21; c++) begin
         tick();
         if (f2a_id_req_o) begin
            pulses++;
            if (prev >= 0 && c - prev != 3) badgap++;
            prev = c;
         end
         acks += int'(f2a_ack_o);
         reqs += int'(fmt_req_o);
      end
      a2f_val_i = 1'b0;
      check("poll_pulses", 64'(pulses), 64'd7);
      check("poll_gap", 64'(badgap), 64'd0);
      check("poll_no_ack", 64'(acks), 64'd0);
      check("poll_no_req", 64'(reqs), 64'd0);
      fixed_q = '{32'h11, 32'h12, 32'h13, 32'h14};
      run_packet(1, 0, 0, 5, 1'b0, -1);
      run_packet(2, 3, 1, 2, 1'b0, -1);
      run_packet(0, 6, 2, 1, 1'b1, -1);
      run_packet(1, 1, 0, 0, 1'b0, 2);
      run_packet(2, 2, 2, 3, 1'b1, -1);
      fixed_q = '{32'h1, 32'h2, 32'h4, 32'h0};
      run_packet(0, 0, 0, 1, 1'b0, -1);
      for (int k = 0; k < 6; k++)
         run_packet($urandom_range(0, 2), $urandom_range(0, 7), 2, $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
